// File: rtl/fb_arbiter.sv
// ============================================================================
// fb_arbiter : single-port frame-buffer arbiter (camera write FIFO vs VGA read)
// Optional macro FB_ARB_DROP_CNT_EN adds a saturating dropped-pixel counter.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module fb_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              write,
  input  logic              frame_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_miss,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        cap_state
`ifdef FB_ARB_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int c_idx_w = $clog2(FIFO_DEPTH);
  localparam int c_ptr_w = c_idx_w + 1;
  localparam int c_stv_w = $clog2(STARVE_MAX + 1);
  localparam int c_ent_w = ADDR_W + DATA_W;
  localparam logic [c_stv_w-1:0] c_stv_max = c_stv_w'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'b00,
    ST_CAPTURE   = 2'b01,
    ST_FROZEN    = 2'b10
  } cap_state_e;

  cap_state_e state_q, state_d;

  logic [c_ent_w-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_stv_w-1:0] starve_q, starve_d;

  logic               rd_pend_q;
  logic               miss_pend_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               rd_valid_q;
  logic               rd_miss_q;
  logic               wr_drop_q;

  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [c_ent_w-1:0] w_head;
  logic               w_grant_wr;
  logic               w_grant_rd;
  logic               w_cap_req;
  logic               w_push;
  logic               w_drop;

  // ---------------------------------------------------------------- capture FSM
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q <= ST_WAIT_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_SYNC: if (frame_done && write)  state_d = ST_CAPTURE;
      ST_CAPTURE:   if (frame_done && !write) state_d = ST_FROZEN;
      ST_FROZEN:    if (write)                state_d = ST_WAIT_SYNC;
      default:                                state_d = ST_WAIT_SYNC;
    endcase
  end

  assign cap_state = state_q;

  // ------------------------------------------------------- arbitration and FIFO
  always_comb begin
    w_fifo_empty = (wr_ptr_q == rd_ptr_q);
    w_fifo_full  = (wr_ptr_q[c_idx_w] != rd_ptr_q[c_idx_w]) &&
                   (wr_ptr_q[c_idx_w-1:0] == rd_ptr_q[c_idx_w-1:0]);
    w_head       = fifo_mem_q[rd_ptr_q[c_idx_w-1:0]];

    // Read wins unless the queued write has waited STARVE_MAX read grants.
    w_grant_wr = !rst && !w_fifo_empty && (!rd_req || (starve_q == c_stv_max));
    w_grant_rd = !rst && rd_req && !w_grant_wr;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    w_cap_req = !rst && (state_q == ST_CAPTURE) && wr_req;
    w_push    = w_cap_req && (!w_fifo_full || w_grant_wr);
    w_drop    = w_cap_req && w_fifo_full && !w_grant_wr;

    wr_ptr_d = wr_ptr_q + c_ptr_w'(w_push);
    rd_ptr_d = rd_ptr_q + c_ptr_w'(w_grant_wr);

    starve_d = '0;
    if (w_grant_rd && !w_fifo_empty) begin
      starve_d = starve_q + c_stv_w'(1);
    end

    mem_en    = w_grant_wr || w_grant_rd;
    mem_we    = w_grant_wr;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_grant_wr) begin
      mem_addr  = w_head[c_ent_w-1:DATA_W];
      mem_wdata = w_head[DATA_W-1:0];
    end else if (w_grant_rd) begin
      mem_addr  = rd_addr;
    end
  end

  always_ff @(posedge clk_50) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q[c_idx_w-1:0]] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      starve_q <= starve_d;
    end
  end

  // ---------------------------------------------- read return, two-stage pipe
  always_ff @(posedge clk_50) begin
    if (rst) begin
      rd_pend_q   <= 1'b0;
      miss_pend_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_miss_q   <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      rd_pend_q   <= w_grant_rd;
      miss_pend_q <= rd_req && w_grant_wr;
      rd_valid_q  <= rd_pend_q;
      rd_miss_q   <= miss_pend_q;
      wr_drop_q   <= w_drop;
      if (rd_pend_q) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_miss  = rd_miss_q;
  assign wr_drop  = wr_drop_q;

`ifdef FB_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((state_q != ST_CAPTURE) && (state_d == ST_CAPTURE)) begin
      drop_cnt_d = '0;
    end else if (wr_drop_q && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire
